next_queue_controller: RTL
==========================

// Module: next_queue_controller
// PURPOSE
//  Owns the upcoming-piece queue shown in the next-piece panel and hands pieces to the game FSM.
//  Generates pieces with a 7-bag randomizer driven by a free-running LFSR, so every 7 draws
//  contain each of I,O,T,J,L,S,Z exactly once. Fills the queue after reset or new game, then
//  pops one piece per request, shifting the queue and appending one new draw in the same cycle.
//  pieces_queue feeds the next-panel pixel driver directly; piece_out feeds the spawn logic.
// PARAMETERS
//  NEXT_PIECES_COUNT  6            queue depth; must match the GamePkg value used by the panel driver
//  LFSR_SEED          16'hACE1     reset seed for the 16-bit LFSR; must be nonzero
// PORTS
//  clk           in   1                     system clock
//  rst_l         in   1                     asynchronous, active-low reset
//  new_game      in   1                     sync pulse: clear queue, refill bag, re-enter FILL
//  piece_req     in   1                     pop request, level-sampled each cycle
//  piece_out     out  tile_type_t           popped piece, valid when piece_valid=1
//  piece_valid   out  1                     1-cycle pulse per accepted pop
//  queue_ready   out  1                     1 = queue full; pops accepted
//  pieces_queue  out  tile_type_t [NEXT_PIECES_COUNT]   [0] = next to pop; to panel driver
// BEHAVIOUR
//  Reset (rst_l=0): state=FILL, fill_cnt=0, bag=7'h7F, lfsr=LFSR_SEED, pieces_queue[*]=BLANK,
//   piece_out=BLANK, piece_valid=0, queue_ready=0.
//  LFSR: 16-bit Galois, mask 16'hB400, advances every cycle in every state; not reseeded by new_game.
//  Draw (combinational): start=lfsr[2:0]; if start==7 then start=0. Chosen index = first set bag
//   bit scanning cyclically start,start+1,...,6,0,... Index->type: 0..6 = I,O,T,J,L,S,Z.
//   Bag update on every draw: clear chosen bit; if result is 7'h00, load 7'h7F in the same cycle.
//  FILL: each cycle write draw into pieces_queue[fill_cnt], fill_cnt++. When fill_cnt reaches
//   NEXT_PIECES_COUNT-1 (this write), next state=READY. queue_ready=1 from the next cycle on.
//   Exactly NEXT_PIECES_COUNT cycles from first FILL cycle to queue_ready=1. piece_req ignored.
//  READY: if piece_req=1 at edge: piece_out<=pieces_queue[0], piece_valid<=1,
//   pieces_queue[k]<=pieces_queue[k+1] for k<N-1, pieces_queue[N-1]<=draw. Else piece_valid<=0,
//   queue and bag hold. Latency req->valid = 1 cycle; back-to-back pops sustain 1/cycle.
//  piece_out holds its last value between pops; queue_ready stays 1 while in READY.
//  new_game=1 (priority over piece_req, any state): pieces_queue[*]<=BLANK, bag<=7'h7F,
//   fill_cnt<=0, piece_valid<=0, queue_ready<=0, state<=FILL; piece_out unchanged.
//  Async reset mid-FILL or mid-pop returns all state to reset values immediately.
//  No BLANK ever appears in pieces_queue while queue_ready=1.
// STRUCTURE
//  GamePkg: tile_type_t (existing), NEXT_PIECES_COUNT, BAG_FULL=7'h7F, LFSR_MASK=16'hB400,
//   function bag_idx_to_tile(logic [2:0]) -> tile_type_t.
//  Sub-module tetromino_bag: holds bag register + LFSR; inputs clk, rst_l, draw_en, clear;
//   output draw (tile_type_t), combinational on current bag/lfsr. Controller = FILL/READY FSM,
//   fill counter, queue shift register.
// TESTING
//  1. Reset, release rst_l -> queue_ready rises exactly 6 cycles later; all 6 entries non-BLANK;
//     no duplicate type among the first 6 entries.
//  2. After ready, 8 pops on consecutive cycles -> 8 piece_valid pulses, each piece_out equals
//     pieces_queue[0] of the prior cycle; concatenation of first 6 fill + pops: every aligned
//     group of 7 draws is a permutation of {I,O,T,J,L,S,Z}.
//  3. piece_req held high during FILL -> piece_valid stays 0; queue_ready still at cycle 6.
//  4. new_game and piece_req both high in READY -> no valid pulse, queue all BLANK next cycle,
//     queue_ready=0, refilled 6 cycles later.
//  5. Assert rst_l=0 mid-FILL (fill_cnt=3) -> outputs at reset values same cycle, no clock needed;
//     after release, fill restarts from entry 0.
//  6. Reference model (same LFSR/draw rule, LFSR_SEED=16'hACE1): 200 random-gap pops -> piece_out
//     sequence matches model exactly; lfsr never reaches 0.

Source files
------------

// File: rtl/next_queue_controller_pkg.sv
// Shared types and constants for the next-piece queue: tile encoding, bag and LFSR constants,
// controller states and the bag-index to tile mapping.
package next_queue_controller_pkg;

    typedef enum logic [2:0] {
        BLANK  = 3'd0,
        TILE_I = 3'd1,
        TILE_O = 3'd2,
        TILE_T = 3'd3,
        TILE_J = 3'd4,
        TILE_L = 3'd5,
        TILE_S = 3'd6,
        TILE_Z = 3'd7
    } tile_type_t;

    typedef enum logic {
        ST_FILL,
        ST_READY
    } ctrl_state_t;

    localparam int         NEXT_PIECES_COUNT = 6;
    localparam logic [6:0] BAG_FULL          = 7'h7F;
    localparam logic [15:0] LFSR_MASK        = 16'hB400;

    // Bag slot order is I,O,T,J,L,S,Z; slot 7 does not exist and maps to BLANK.
    function automatic tile_type_t bag_idx_to_tile(input logic [2:0] idx);
        tile_type_t t;
        case (idx)
            3'd0:    t = TILE_I;
            3'd1:    t = TILE_O;
            3'd2:    t = TILE_T;
            3'd3:    t = TILE_J;
            3'd4:    t = TILE_L;
            3'd5:    t = TILE_S;
            3'd6:    t = TILE_Z;
            default: t = BLANK;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/next_queue_controller_if.sv
// Handshake between the game FSM / next-panel driver (master) and the queue controller (slave).
interface next_queue_controller_if #(
    parameter int N = 6
);
    import next_queue_controller_pkg::*;

    logic       new_game;
    logic       piece_req;
    tile_type_t piece_out;
    logic       piece_valid;
    logic       queue_ready;
    tile_type_t pieces_queue [N];

    modport master (
        output new_game,
        output piece_req,
        input  piece_out,
        input  piece_valid,
        input  queue_ready,
        input  pieces_queue
    );

    modport slave (
        input  new_game,
        input  piece_req,
        output piece_out,
        output piece_valid,
        output queue_ready,
        output pieces_queue
    );

endinterface

// File: rtl/next_queue_controller_bag.sv
// 7-bag randomizer: free-running Galois LFSR picks a starting slot, the first remaining bag slot
// found scanning cyclically from there is the draw. The bag reloads as soon as it empties.
module next_queue_controller_bag
    import next_queue_controller_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       draw_en,
    input  logic       clear,
    output tile_type_t draw
);

    logic [15:0] lfsr;
    logic [6:0]  bag;
    logic [6:0]  bag_cleared;
    logic [2:0]  start;
    logic [2:0]  chosen;
    logic [2:0]  cand;
    logic [3:0]  sum;
    logic        found;

    always_comb begin
        start       = (lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0];
        chosen      = 3'd0;
        found       = 1'b0;
        sum         = 4'd0;
        cand        = 3'd0;
        for (int k = 0; k < 7; k++) begin
            sum  = {1'b0, start} + 4'(k);
            cand = (sum >= 4'd7) ? 3'(sum - 4'd7) : sum[2:0];
            if (!found && bag[cand]) begin
                chosen = cand;
                found  = 1'b1;
            end
        end
        bag_cleared = bag & ~(7'b1 << chosen);
        draw        = bag_idx_to_tile(chosen);
    end

    // The LFSR keeps running through every state so the sequence depends on game timing.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            lfsr <= LFSR_SEED;
            bag  <= BAG_FULL;
        end else begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
            if (clear) begin
                bag <= BAG_FULL;
            end else if (draw_en) begin
                bag <= (bag_cleared == 7'h00) ? BAG_FULL : bag_cleared;
            end
        end
    end

endmodule

// File: rtl/next_queue_controller.sv
// Upcoming-piece queue: fills from the bag after reset/new game, then pops one piece per request
// while shifting the queue and appending a fresh draw in the same cycle.
module next_queue_controller
    import next_queue_controller_pkg::*;
#(
    parameter int          NEXT_PIECES_COUNT = 6,
    parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst_l,
    next_queue_controller_if.slave  bus
);

    localparam int N  = NEXT_PIECES_COUNT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    ctrl_state_t state;
    ctrl_state_t state_nxt;
    logic [CW-1:0] fill_cnt;
    logic          draw_en;
    logic          fill;
    logic          pop;
    tile_type_t    draw;
    tile_type_t    queue [N];
    tile_type_t    piece_out;
    logic          piece_valid;

    next_queue_controller_bag #(
        .LFSR_SEED (LFSR_SEED)
    ) u_bag (
        .clk     (clk),
        .rst_l   (rst_l),
        .draw_en (draw_en),
        .clear   (bus.new_game),
        .draw    (draw)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // new_game overrides whatever the current state would do, including a pending pop.
    always_comb begin
        state_nxt = state;
        draw_en   = 1'b0;
        fill      = 1'b0;
        pop       = 1'b0;
        case (state)
            ST_FILL: begin
                fill    = 1'b1;
                draw_en = 1'b1;
                if (fill_cnt == CW'(N - 1)) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (bus.piece_req) begin
                    pop     = 1'b1;
                    draw_en = 1'b1;
                end
            end
            default: state_nxt = ST_FILL;
        endcase
        if (bus.new_game) begin
            state_nxt = ST_FILL;
            draw_en   = 1'b0;
            fill      = 1'b0;
            pop       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            fill_cnt    <= '0;
            piece_out   <= BLANK;
            piece_valid <= 1'b0;
            for (int k = 0; k < N; k++) begin
                queue[k] <= BLANK;
            end
        end else begin
            piece_valid <= pop;
            if (bus.new_game) begin
                fill_cnt <= '0;
                for (int k = 0; k < N; k++) begin
                    queue[k] <= BLANK;
                end
            end else if (fill) begin
                queue[fill_cnt] <= draw;
                fill_cnt        <= fill_cnt + 1'b1;
            end else if (pop) begin
                piece_out <= queue[0];
                for (int k = 0; k < N - 1; k++) begin
                    queue[k] <= queue[k + 1];
                end
                queue[N - 1] <= draw;
            end
        end
    end

    assign bus.piece_out    = piece_out;
    assign bus.piece_valid  = piece_valid;
    assign bus.queue_ready  = (state == ST_READY);
    assign bus.pieces_queue = queue;

endmodule
